// File: rtl/ysyx_ctrl_pkg.sv
// rtl/ysyx_ctrl_pkg.sv - shared types and constants for the ysyx control sequencer
// Contents:
//   ctrl_state_e  : sequencer states
//   NOP_INST      : reset value of the instruction register (addi x0, x0, 0)
//   DM_RD_* / DM_WR_* : load/store type encodings shared with the decoder
//   is_mem_op()   : true when the decoded instruction needs a data-memory access
package ysyx_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_IWAIT,
        S_EXEC,
        S_MREQ,
        S_MWAIT,
        S_WB,
        S_HALT,
        S_ERROR
    } ctrl_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [2:0] DM_RD_NONE = 3'd0;
    localparam logic [2:0] DM_RD_LB   = 3'd1;
    localparam logic [2:0] DM_RD_LBU  = 3'd2;
    localparam logic [2:0] DM_RD_LH   = 3'd3;
    localparam logic [2:0] DM_RD_LHU  = 3'd4;
    localparam logic [2:0] DM_RD_LW   = 3'd5;

    localparam logic [1:0] DM_WR_NONE = 2'd0;
    localparam logic [1:0] DM_WR_SB   = 2'd1;
    localparam logic [1:0] DM_WR_SH   = 2'd2;
    localparam logic [1:0] DM_WR_SW   = 2'd3;

    function automatic logic is_mem_op(input logic [2:0] rd_sel, input logic [1:0] wr_sel);
        return (rd_sel != DM_RD_NONE) || (wr_sel != DM_WR_NONE);
    endfunction

endpackage

// File: rtl/ysyx_ctrl_fsm_if.sv
// rtl/ysyx_ctrl_fsm_if.sv - instruction/data memory handshake bundle for the control sequencer
// Signals:
//   ifu_req_valid/ifu_req_ready : instruction fetch request handshake
//   ifu_rsp_valid/ifu_rsp_data  : fetched instruction word
//   lsu_req_valid/lsu_req_wen/lsu_req_ready : data memory request (wen=1 store)
//   lsu_rsp_valid               : load data / store completion
// Modports: master = sequencer side, slave = memory side.
interface ysyx_ctrl_fsm_if;

    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_data;
    logic        lsu_req_valid;
    logic        lsu_req_wen;
    logic        lsu_req_ready;
    logic        lsu_rsp_valid;

    modport master (
        output ifu_req_valid,
        input  ifu_req_ready,
        input  ifu_rsp_valid,
        input  ifu_rsp_data,
        output lsu_req_valid,
        output lsu_req_wen,
        input  lsu_req_ready,
        input  lsu_rsp_valid
    );

    modport slave (
        input  ifu_req_valid,
        output ifu_req_ready,
        output ifu_rsp_valid,
        output ifu_rsp_data,
        input  lsu_req_valid,
        input  lsu_req_wen,
        output lsu_req_ready,
        output lsu_rsp_valid
    );

endinterface

// File: rtl/ysyx_timeout_cnt.sv
// rtl/ysyx_timeout_cnt.sv - memory response wait counter
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : force count to zero (held while not waiting)
//   en       : count one waiting cycle
//   expired  : this waiting cycle is the TIMEOUT-th one
module ysyx_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int               CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The count reaches TIMEOUT at the end of the cycle where cnt_q == TIMEOUT-1,
    // so that cycle is flagged; the FSM lets a same-cycle response take priority.
    assign expired = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ysyx_ctrl_fsm.sv
// rtl/ysyx_ctrl_fsm.sv - multi-cycle fetch/execute/memory/writeback sequencer
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   mem            : instruction/data memory handshakes (master side)
//   ir             : instruction register driving the decoder
//   dec_*          : decoder results for the instruction in ir
//   rf_we, pc_we   : one-cycle architectural write strobes (WB only)
//   halted, err    : sticky ebreak / memory-timeout indications
// All outputs are decodes of registered state.
module ysyx_ctrl_fsm
    import ysyx_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_ctrl_fsm_if.master       mem,
    output logic [31:0]           ir,
    input  logic                  dec_rf_wr_en,
    input  logic [2:0]            dec_dm_rd_sel,
    input  logic [1:0]            dec_dm_wr_sel,
    input  logic                  dec_ebreak,
    output logic                  rf_we,
    output logic                  pc_we,
    output logic                  halted,
    output logic                  err
);

    ctrl_state_e state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        rf_wr_en_q, rf_wr_en_d;
    logic        lsu_wen_q, lsu_wen_d;
    logic        in_wait;
    logic        tmo_expired;

    assign in_wait = (state_q == S_IWAIT) || (state_q == S_MWAIT);

    // Held clear outside the wait states, so every wait starts from zero.
    ysyx_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (!in_wait),
        .en      (in_wait),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        rf_wr_en_d = rf_wr_en_q;
        lsu_wen_d  = lsu_wen_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (mem.ifu_req_ready) begin
                    state_d = S_IWAIT;
                end
            end
            S_IWAIT: begin
                // Response is checked first so it wins over a same-cycle timeout.
                if (mem.ifu_rsp_valid) begin
                    ir_d    = mem.ifu_rsp_data;
                    state_d = S_EXEC;
                end else if (tmo_expired) begin
                    state_d = S_ERROR;
                end
            end
            S_EXEC: begin
                // Capture decoder results here so later strobes are pure state decodes.
                rf_wr_en_d = dec_rf_wr_en;
                lsu_wen_d  = (dec_dm_wr_sel != DM_WR_NONE);
                if (dec_ebreak) begin
                    state_d = S_HALT;
                end else if (is_mem_op(dec_dm_rd_sel, dec_dm_wr_sel)) begin
                    state_d = S_MREQ;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MREQ: begin
                if (mem.lsu_req_ready) begin
                    state_d = S_MWAIT;
                end
            end
            S_MWAIT: begin
                if (mem.lsu_rsp_valid) begin
                    state_d = S_WB;
                end else if (tmo_expired) begin
                    state_d = S_ERROR;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ir_q       <= NOP_INST;
            rf_wr_en_q <= 1'b0;
            lsu_wen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            rf_wr_en_q <= rf_wr_en_d;
            lsu_wen_q  <= lsu_wen_d;
        end
    end

    assign mem.ifu_req_valid = (state_q == S_FETCH);
    assign mem.lsu_req_valid = (state_q == S_MREQ);
    assign mem.lsu_req_wen   = (state_q == S_MREQ) && lsu_wen_q;
    assign rf_we             = (state_q == S_WB) && rf_wr_en_q;
    assign pc_we             = (state_q == S_WB);
    assign halted            = (state_q == S_HALT);
    assign err               = (state_q == S_ERROR);
    assign ir                = ir_q;

endmodule
